// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_word,
                                                 input logic [WORD_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Synchronous byte-enabled RAM: registered read of addr every cycle, lane-masked write.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic              wr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= be_merge(mem[addr], wdata, be);
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ready/rvalid handshake, LATENCY wait states, range check.
// Define DMEM_MMIO_EN to map a byte-lane writable output register at MMIO_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [31:0]       daddr,
  input  logic [WORD_W-1:0] dwdata,
  input  logic [BE_W-1:0]   we,
  output logic              ready,
  output logic              rvalid,
  output logic [WORD_W-1:0] drdata,
  output logic              err,
  output logic [WORD_W-1:0] mmio_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_MMIO_EN
  localparam bit MmioEn = 1'b1;
`else
  localparam bit MmioEn = 1'b0;
`endif

  dmem_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       daddr_q;
  logic [WORD_W-1:0] dwdata_q;
  logic [BE_W-1:0]   we_q;
  logic              accept;

  logic              is_write, misaligned, out_of_range, mmio_hit, acc_err;
  logic [AW-1:0]     bank_addr;
  logic              bank_wr;
  logic [WORD_W-1:0] bank_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      we_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        daddr_q  <= daddr;
        dwdata_q <= dwdata;
        we_q     <= we;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ready   = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = 3'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 3'd1;
      end
      RESP: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode is done on the latched request; upper address bits must be zero, no wrap.
  assign is_write     = |we_q;
  assign misaligned   = |daddr_q[1:0];
  assign out_of_range = {2'b00, daddr_q[31:2]} >= DEPTH_WORDS;
  assign mmio_hit     = MmioEn && !misaligned && (daddr_q[31:2] == MMIO_ADDR[31:2]);
  assign acc_err      = misaligned || (out_of_range && !mmio_hit);

  // Present the incoming address while idle so the registered read lands in RESP at LATENCY=0.
  assign bank_addr = (state_q == IDLE) ? daddr[AW+1:2] : daddr_q[AW+1:2];
  assign bank_wr   = rvalid && is_write && !acc_err && !mmio_hit;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk   (clk),
    .addr  (bank_addr),
    .wdata (dwdata_q),
    .be    (we_q),
    .wr    (bank_wr),
    .rdata (bank_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [WORD_W-1:0] mmio_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_q <= '0;
    end else if (rvalid && is_write && mmio_hit) begin
      mmio_q <= be_merge(mmio_q, dwdata_q, we_q);
    end
  end

  assign mmio_out = mmio_q;
`else
  assign mmio_out = '0;
`endif

  assign err    = rvalid && acc_err;
  assign drdata = (rvalid && !is_write && !acc_err) ? (mmio_hit ? mmio_out : bank_rdata) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: three instances (LATENCY 2, 3, 0) against a word-array model.
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] MMIO_A = 32'h0000_FFFC;
  localparam int          NDUT   = 3;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [NDUT];
  logic [31:0] daddr  [NDUT];
  logic [31:0] dwdata [NDUT];
  logic [3:0]  we     [NDUT];
  logic        ready  [NDUT];
  logic        rvalid [NDUT];
  logic        err    [NDUT];
  logic [31:0] drdata [NDUT];
  logic [31:0] mmio_out [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m  [NDUT][DEPTH];
  logic [31:0] mmio_m [NDUT];

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 0);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 3 : 0)),
      .MMIO_ADDR   (MMIO_A)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .req      (req[g]),
      .daddr    (daddr[g]),
      .dwdata   (dwdata[g]),
      .we       (we[g]),
      .ready    (ready[g]),
      .rvalid   (rvalid[g]),
      .drdata   (drdata[g]),
      .err      (err[g]),
      .mmio_out (mmio_out[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: decides response and applies side effects from the access rules.
  task automatic model_ref(input int d, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] be, output logic [31:0] rd, output logic e);
    logic        hit;
    int unsigned idx;
    hit = MMIO_ON && (a == MMIO_A);
    idx = a >> 2;
    rd  = '0;
    e   = 1'b0;
    if (a[1:0] != 2'b00 || (!hit && idx >= DEPTH)) begin
      e = 1'b1;
    end else if (be != 4'h0) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (hit) mmio_m[d][8*i +: 8] = w[8*i +: 8];
          else     mem_m[d][idx][8*i +: 8] = w[8*i +: 8];
        end
      end
    end else begin
      rd = hit ? mmio_m[d] : mem_m[d][idx];
    end
  endtask

  task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] be, output logic [31:0] rd_o);
    logic [31:0] exp_rd, got_rd;
    logic        exp_err, got_err;
    int          lat, n;
    model_ref(d, a, w, be, exp_rd, exp_err);
    got_rd  = 'x;
    got_err = 1'bx;
    lat     = -1;
    @(negedge clk);
    req[d] = 1'b1; daddr[d] = a; dwdata[d] = w; we[d] = be;
    n = 0;
    while (ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("d%0d ready_wait", d), 32'(ready[d]), 32'd1);
    @(posedge clk);
    #1 req[d] = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (rvalid[d] === 1'b1) begin
        lat     = k - 1;
        got_rd  = drdata[d];
        got_err = err[d];
      end
    end
    check_eq($sformatf("d%0d latency a=%h", d, a), lat, lat_of(d));
    check_eq($sformatf("d%0d drdata a=%h we=%h", d, a, be), got_rd, exp_rd);
    check_eq($sformatf("d%0d err a=%h", d, a), 32'(got_err), 32'(exp_err));
    @(negedge clk);
    check_eq($sformatf("d%0d ready_after", d), 32'(ready[d]), 32'd1);
    check_eq($sformatf("d%0d rvalid_single", d), 32'(rvalid[d]), 32'd0);
    check_eq($sformatf("d%0d mmio_out", d), mmio_out[d], mmio_m[d]);
    rd_o = got_rd;
  endtask

  // req held high: ready once every LATENCY+2 cycles, rvalid on the last cycle of each period.
  task automatic hold_test(input int d, input logic [31:0] a);
    int p;
    p = lat_of(d) + 2;
    @(negedge clk);
    req[d] = 1'b1; daddr[d] = a; dwdata[d] = '0; we[d] = 4'h0;
    for (int c = 0; c < 4 * p; c++) begin
      check_eq($sformatf("d%0d hold ready c=%0d", d, c), 32'(ready[d]), 32'(c % p == 0));
      check_eq($sformatf("d%0d hold rvalid c=%0d", d, c), 32'(rvalid[d]), 32'(c % p == p - 1));
      if (c % p == p - 1)
        check_eq($sformatf("d%0d hold drdata", d), drdata[d], mem_m[d][a >> 2]);
      @(negedge clk);
    end
    req[d] = 1'b0;
    check_eq($sformatf("d%0d hold end ready", d), 32'(ready[d]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd0, a;
    logic [3:0]  be;
    int          sel, idx;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; daddr[d] = '0; dwdata[d] = '0; we[d] = '0; mmio_m[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("d%0d reset ready", d), 32'(ready[d]), 32'd1);
      check_eq($sformatf("d%0d reset rvalid", d), 32'(rvalid[d]), 32'd0);
      check_eq($sformatf("d%0d reset drdata", d), drdata[d], 32'd0);
      check_eq($sformatf("d%0d reset err", d), 32'(err[d]), 32'd0);
      check_eq($sformatf("d%0d reset mmio", d), mmio_out[d], 32'd0);
    end
    rst_n = 1'b1;

    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < DEPTH; i++) run_txn(d, 32'(i * 4), $urandom(), 4'hF, rd);

    // Directed sequence on the LATENCY=2 instance.
    run_txn(0, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    run_txn(0, 32'h10, 32'h0, 4'h0, rd);
    check_eq("read_deadbeef", rd, 32'hDEADBEEF);
    run_txn(0, 32'h10, 32'h11223344, 4'b0101, rd);
    run_txn(0, 32'h10, 32'h0, 4'h0, rd);
    check_eq("byte_lanes", rd, 32'hDE22BE44);
    run_txn(0, 32'h12, 32'h0, 4'h0, rd);
    run_txn(0, 32'h0, 32'h0, 4'h0, rd0);
    run_txn(0, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF, rd);
    run_txn(0, 32'h0, 32'h0, 4'h0, rd);
    check_eq("oor_write_no_effect", rd, rd0);

    run_txn(0, MMIO_A, 32'h0000_00A5, 4'hF, rd);
    run_txn(0, MMIO_A, 32'h0, 4'h0, rd);
`ifdef DMEM_MMIO_EN
    check_eq("mmio_read", rd, 32'h0000_00A5);
    check_eq("mmio_out_val", mmio_out[0], 32'h0000_00A5);
`else
    check_eq("mmio_off_out", mmio_out[0], 32'h0);
`endif

    // Reset while a write sits in WAIT on the LATENCY=3 instance.
    @(negedge clk);
    req[1] = 1'b1; daddr[1] = 32'h20; dwdata[1] = 32'hCAFEF00D; we[1] = 4'hF;
    check_eq("midrst accept_ready", 32'(ready[1]), 32'd1);
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    check_eq("midrst in_wait", 32'(ready[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst async ready", 32'(ready[1]), 32'd1);
    check_eq("midrst async rvalid", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < NDUT; d++) mmio_m[d] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst no_rvalid", 32'(rvalid[1]), 32'd0);
      check_eq("midrst ready", 32'(ready[1]), 32'd1);
    end
    run_txn(1, 32'h20, 32'h0, 4'h0, rd);

    hold_test(2, 32'h10);
    hold_test(0, 32'h10);

    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 80; t++) begin
        sel = $urandom_range(0, 9);
        idx = $urandom_range(0, DEPTH - 1);
        case (sel)
          6:       a = 32'(idx * 4 + $urandom_range(1, 3));
          7: begin
            a = $urandom() | 32'h0001_0000;
            a[1:0] = 2'b00;
          end
          8:       a = MMIO_A;
          9:       a = ($urandom_range(0, 1) != 0) ? 32'(DEPTH * 4) : 32'((DEPTH - 1) * 4);
          default: a = 32'(idx * 4);
        endcase
        be = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        run_txn(d, a, $urandom(), be, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core: the memory end of the CPU data port (daddr, dwdata, we[3:0] byte enables, drdata).
- Adds a req/ready/rvalid handshake and programmable wait states so the core can be tested against non-ideal memory.
- Serves one outstanding transaction at a time, with byte-lane writes, range checking and an optional memory-mapped output register.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of 2.
- LATENCY, 1: wait states between accept and response; legal range 0..7.
- MMIO_ADDR, 32'h0000_FFFC: byte address of the output register (used only with DMEM_MMIO_EN).

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  initiator has a valid request.
- daddr  in  32  byte address; must be word-aligned.
- dwdata  in  32  write data; lane i is dwdata[8i+7:8i].
- we  in  4  byte write enables; 4'b0000 means read.
- ready  out  1  responder can accept a request this cycle.
- rvalid  out  1  one-cycle response strobe.
- drdata  out  32  read data; valid only while rvalid=1.
- err  out  1  error flag, qualified by rvalid.
- mmio_out  out  32  memory-mapped output register.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, ready=1, rvalid=0, drdata=0, err=0, mmio_out=0, wait counter=0. The memory array is never reset.
- State IDLE: ready=1.
  - On req=1, latch daddr/dwdata/we.
  - If LATENCY=0, go to RESP; otherwise load counter with LATENCY-1 and go to WAIT.
- State WAIT: ready=0. Decrement counter each cycle; at 0, go to RESP.
- State RESP: ready=0, rvalid=1 for exactly one cycle, then go to IDLE. ready returns to 1 on the next cycle.
- Latency: accept at edge N; rvalid is high in cycle N+1+LATENCY. The minimum accept-to-accept spacing is LATENCY+2 cycles.
- Writes (we≠0):
  - Array update happens at the RESP edge, lanes with we[i]=1 only.
  - drdata=0 on a write response.
- Reads (we=0): drdata is the word at daddr[31:2], sampled at RESP. A read immediately after a write returns the new data.
- Errors: err=1 with rvalid when daddr[1:0]≠0 or word index ≥ DEPTH_WORDS.
  - Do not write the array.
  - drdata=0.
- Address index: daddr[2+$clog2(DEPTH_WORDS)-1:2]. Upper bits participate in the range check, with no wrap-around.
- req while ready=0 is ignored; the initiator must hold req until it sees ready.
- Reset mid-transaction: return to IDLE with no response. A pending write is dropped and the array is unchanged.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- With the macro defined:
  - A word-aligned access to MMIO_ADDR targets mmio_out instead of the array; the range check is bypassed.
  - Writes update mmio_out per byte lane at the RESP edge.
  - Reads return mmio_out.
- Without the macro defined:
  - mmio_out is tied to 0.
  - MMIO_ADDR is treated as an ordinary address, so out-of-range accesses set err.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t.
  - localparam WORD_W=32 and BE_W=4.
  - Function be_merge(old, new, be): byte-lane merge.
- Sub-module dmem_bank: a synchronous byte-enabled RAM with ports clk, addr, wdata, be, wr, rdata. dmem_responder owns the FSM, counter, range check and MMIO.

Test Plan:
- LATENCY=2, reset, then write we=4'hF, daddr=32'h10, dwdata=32'hDEADBEEF. Required: rvalid exactly 3 cycles after accept, err=0, then ready=1 one cycle after rvalid. A read of 32'h10 returns 32'hDEADBEEF.
- Byte lanes: after writing 32'hDEADBEEF at 32'h10, write we=4'b0101 with dwdata=32'h11223344. Required: a read returns 32'hDE22BE44.
- Errors: read at daddr=32'h12 gives rvalid=1, err=1, drdata=0. A write at daddr=DEPTH_WORDS*4 gives err=1, and a readback of word 0 is unchanged.
- Reset mid-operation: accept a write of 32'hCAFEF00D to 32'h20 with LATENCY=3, then pulse reset low during WAIT. Required: no rvalid, ready=1 after release, and a read of 32'h20 returns the prior value.
- Back-pressure: hold req=1 continuously with LATENCY=0. Required: an accept every 2 cycles, and rvalid never high in two consecutive cycles.
- MMIO (DMEM_MMIO_EN defined): write 32'h000000A5 to MMIO_ADDR. Required: mmio_out=32'h000000A5 one cycle after RESP, and a read returns the same value. With the macro undefined, the same write gives err=1 and mmio_out=0.
